// File: rtl/tag_rx_hop_integrator_pkg.sv
// Shared definitions for the hop integrator and the host readback decoder:
// state encoding, default widths and the record packing order {hop, count, sat, isum, qsum}.
package tag_rx_hop_integrator_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_CNT_WIDTH  = 16;
    localparam int DEF_HOP_WIDTH  = 7;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic {
        STATE_IDLE  = 1'b0,
        STATE_ACCUM = 1'b1
    } state_t;

    // Packed record is {hop, count, sat, isum, qsum}, qsum in the LSBs.
    function automatic int rec_width(input int hop_w, input int cnt_w, input int acc_w);
        return hop_w + cnt_w + 1 + 2 * acc_w;
    endfunction

endpackage

// File: rtl/tag_rx_hop_integrator_if.sv
// Sample input and record output stream of the hop integrator.
// slave = integrator side, master = RX controller / host side.
interface tag_rx_hop_integrator_if
    import tag_rx_hop_integrator_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int HOP_WIDTH  = DEF_HOP_WIDTH,
    parameter int ACC_WIDTH  = DATA_WIDTH + CNT_WIDTH
) ();

    logic                         rx_valid;
    logic signed [DATA_WIDTH-1:0] irx_in;
    logic signed [DATA_WIDTH-1:0] qrx_in;
    logic                         hop_clk;
    logic                         hop_rst;
    logic [HOP_WIDTH-1:0]         nhop;

    logic                         o_tvalid;
    logic                         o_tready;
    logic [HOP_WIDTH-1:0]         o_hop;
    logic [CNT_WIDTH-1:0]         o_count;
    logic signed [ACC_WIDTH-1:0]  o_isum;
    logic signed [ACC_WIDTH-1:0]  o_qsum;
    logic                         o_sat;

    modport master (
        output rx_valid, irx_in, qrx_in, hop_clk, hop_rst, nhop, o_tready,
        input  o_tvalid, o_hop, o_count, o_isum, o_qsum, o_sat
    );

    modport slave (
        input  rx_valid, irx_in, qrx_in, hop_clk, hop_rst, nhop, o_tready,
        output o_tvalid, o_hop, o_count, o_isum, o_qsum, o_sat
    );

endinterface

// File: rtl/tag_rx_hop_integrator_fifo.sv
// Synchronous record FIFO with a registered first-word-fall-through output.
// Capacity is DEPTH records in total, including the word presented on rd_data.
module tag_rec_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_next;
    logic [CNT_W-1:0] used, used_next;
    logic [WIDTH-1:0] head_next;
    logic             push, pop;

    assign full = (used == CNT_W'(DEPTH));
    assign pop  = ~empty & rd_ready;
    assign push = wr_en & (~full | pop);

    // The next head comes straight from wr_data when the word being written is the one
    // about to be presented, so a push into an empty FIFO is visible the next cycle.
    always_comb begin
        rd_ptr_next = pop ? rd_ptr + 1'b1 : rd_ptr;
        used_next   = used + CNT_W'(push) - CNT_W'(pop);
        head_next   = (push && (rd_ptr_next == wr_ptr)) ? wr_data : mem[rd_ptr_next];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            used    <= '0;
            empty   <= 1'b1;
            rd_data <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_ptr_next;
            used   <= used_next;
            empty  <= (used_next == '0);
            if (used_next != '0) begin
                rd_data <= head_next;
            end
        end
    end

endmodule

// File: rtl/tag_rx_hop_integrator.sv
// Integrates I/Q samples over each frequency hop and queues one
// {hop, count, sat, isum, qsum} record per completed hop toward the host.
module tag_rx_hop_integrator
    import tag_rx_hop_integrator_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int HOP_WIDTH  = DEF_HOP_WIDTH,
    parameter int ACC_WIDTH  = DATA_WIDTH + CNT_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset,
    tag_rx_hop_integrator_if.slave  bus,
    output logic                    overflow,
    output logic                    state
);

    localparam int REC_WIDTH = rec_width(HOP_WIDTH, CNT_WIDTH, ACC_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t                      state_q, state_d;
    logic                        hop_clk_q, hop_edge;
    logic [HOP_WIDTH-1:0]        hop_q, hop_d;
    logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
    logic signed [ACC_WIDTH-1:0] isum_q, isum_d, qsum_q, qsum_d;
    logic signed [ACC_WIDTH-1:0] irx_ext, qrx_ext;
    logic                        sat_q, sat_d;
    logic                        overflow_q;
    logic                        push;
    logic                        fifo_full, fifo_empty;
    logic [REC_WIDTH-1:0]        rec_in, rec_out;

    assign hop_edge = bus.hop_clk & ~hop_clk_q;
    assign irx_ext  = {{(ACC_WIDTH-DATA_WIDTH){bus.irx_in[DATA_WIDTH-1]}}, bus.irx_in};
    assign qrx_ext  = {{(ACC_WIDTH-DATA_WIDTH){bus.qrx_in[DATA_WIDTH-1]}}, bus.qrx_in};

    // hop_rst outranks a coincident edge; a sample on an edge cycle opens the new hop.
    always_comb begin
        state_d = state_q;
        hop_d   = hop_q;
        cnt_d   = cnt_q;
        isum_d  = isum_q;
        qsum_d  = qsum_q;
        sat_d   = sat_q;
        push    = 1'b0;
        if (bus.hop_rst) begin
            state_d = STATE_IDLE;
            cnt_d   = '0;
            isum_d  = '0;
            qsum_d  = '0;
            sat_d   = 1'b0;
        end else begin
            case (state_q)
                STATE_IDLE: begin
                    if (hop_edge) begin
                        state_d = STATE_ACCUM;
                        hop_d   = bus.nhop;
                        cnt_d   = '0;
                        isum_d  = '0;
                        qsum_d  = '0;
                        sat_d   = 1'b0;
                    end
                end
                STATE_ACCUM: begin
                    if (hop_edge) begin
                        push   = 1'b1;
                        hop_d  = bus.nhop;
                        cnt_d  = {{(CNT_WIDTH-1){1'b0}}, bus.rx_valid};
                        isum_d = bus.rx_valid ? irx_ext : '0;
                        qsum_d = bus.rx_valid ? qrx_ext : '0;
                        sat_d  = 1'b0;
                    end else if (bus.rx_valid) begin
                        if (cnt_q != CNT_MAX) begin
                            cnt_d  = cnt_q + 1'b1;
                            isum_d = isum_q + irx_ext;
                            qsum_d = qsum_q + qrx_ext;
                        end else begin
                            sat_d = 1'b1;
                        end
                    end
                end
                default: state_d = STATE_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= STATE_IDLE;
            hop_clk_q  <= 1'b0;
            hop_q      <= '0;
            cnt_q      <= '0;
            isum_q     <= '0;
            qsum_q     <= '0;
            sat_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hop_clk_q  <= bus.hop_clk;
            hop_q      <= hop_d;
            cnt_q      <= cnt_d;
            isum_q     <= isum_d;
            qsum_q     <= qsum_d;
            sat_q      <= sat_d;
            overflow_q <= overflow_q | (push & fifo_full & ~(~fifo_empty & bus.o_tready));
        end
    end

    assign rec_in = {hop_q, cnt_q, sat_q, isum_q, qsum_q};

    tag_rec_fifo #(
        .WIDTH (REC_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (push),
        .wr_data  (rec_in),
        .rd_ready (bus.o_tready),
        .rd_data  (rec_out),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign bus.o_tvalid = ~fifo_empty;
    assign bus.o_qsum   = rec_out[ACC_WIDTH-1:0];
    assign bus.o_isum   = rec_out[2*ACC_WIDTH-1:ACC_WIDTH];
    assign bus.o_sat    = rec_out[2*ACC_WIDTH];
    assign bus.o_count  = rec_out[2*ACC_WIDTH+CNT_WIDTH:2*ACC_WIDTH+1];
    assign bus.o_hop    = rec_out[REC_WIDTH-1:REC_WIDTH-HOP_WIDTH];

    assign overflow = overflow_q;
    assign state    = state_q;

endmodule

// File: tb/tb_tag_rx_hop_integrator.sv
// Scoreboard bench for tag_rx_hop_integrator: expected records are queued as hops are driven
// and compared as they leave the DUT; a second instance with a 4-bit counter covers saturation.
`timescale 1ns/1ps
module tb_tag_rx_hop_integrator;

    typedef struct {
        logic [6:0]         hop;
        logic [15:0]        count;
        logic signed [31:0] isum;
        logic signed [31:0] qsum;
        logic               sat;
    } rec_t;

    logic clk = 1'b0;
    logic reset;
    logic overflow, state, overflow2, state2;
    int   total = 0;
    int   bad   = 0;
    rec_t exp_q[$];

    tag_rx_hop_integrator_if #(.DATA_WIDTH(16), .CNT_WIDTH(16), .HOP_WIDTH(7)) bus ();
    tag_rx_hop_integrator_if #(.DATA_WIDTH(16), .CNT_WIDTH(4),  .HOP_WIDTH(7)) bus2 ();

    tag_rx_hop_integrator #(
        .DATA_WIDTH(16), .CNT_WIDTH(16), .HOP_WIDTH(7), .ACC_WIDTH(32), .FIFO_DEPTH(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .overflow (overflow),
        .state    (state)
    );

    tag_rx_hop_integrator #(
        .DATA_WIDTH(16), .CNT_WIDTH(4), .HOP_WIDTH(7), .ACC_WIDTH(20), .FIFO_DEPTH(4)
    ) dut_sat (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus2),
        .overflow (overflow2),
        .state    (state2)
    );

    assign bus2.rx_valid = bus.rx_valid;
    assign bus2.irx_in   = bus.irx_in;
    assign bus2.qrx_in   = bus.qrx_in;
    assign bus2.hop_clk  = bus.hop_clk;
    assign bus2.hop_rst  = bus.hop_rst;
    assign bus2.nhop     = bus.nhop;
    assign bus2.o_tready = 1'b1;

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int i, input int q, input bit hc, input bit hr, input int nh);
        bus.rx_valid = v;
        bus.irx_in   = 16'(i);
        bus.qrx_in   = 16'(q);
        bus.hop_clk  = hc;
        bus.hop_rst  = hr;
        bus.nhop     = 7'(nh);
    endtask

    task automatic cycle(input bit v, input int i, input int q, input bit hc, input bit hr, input int nh);
        drive(v, i, q, hc, hr, nh);
        tick(1);
    endtask

    task automatic expect_rec(input int hop, input int count, input int isum, input int qsum, input bit sat);
        rec_t r;
        r.hop   = 7'(hop);
        r.count = 16'(count);
        r.isum  = isum;
        r.qsum  = qsum;
        r.sat   = sat;
        exp_q.push_back(r);
    endtask

    // Handshakes are sampled on the falling edge, half a cycle before the pop takes effect.
    initial begin : monitor
        rec_t e;
        forever begin
            @(negedge clk);
            if (bus.o_tvalid === 1'b1 && bus.o_tready === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL record_unexpected: got hop=%0d count=%0d isum=%0d qsum=%0d, required no record",
                             bus.o_hop, bus.o_count, bus.o_isum, bus.o_qsum);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.o_hop !== e.hop || bus.o_count !== e.count || bus.o_isum !== e.isum ||
                        bus.o_qsum !== e.qsum || bus.o_sat !== e.sat) begin
                        bad++;
                        $display("[TB] FAIL record: got hop=%0d count=%0d isum=%0d qsum=%0d sat=%0b, required hop=%0d count=%0d isum=%0d qsum=%0d sat=%0b",
                                 bus.o_hop, bus.o_count, bus.o_isum, bus.o_qsum, bus.o_sat,
                                 e.hop, e.count, e.isum, e.qsum, e.sat);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic test_reset();
        bus.o_tready = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick(100);
        reset = 1'b0;
        tick(1);
        total++;
        if (state !== 1'b0) begin bad++; $display("[TB] FAIL reset_state: got %0b, required 0", state); end
        total++;
        if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL reset_overflow: got %0b, required 0", overflow); end
        total++;
        if (bus.o_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL reset_tvalid: got %0b, required 0", bus.o_tvalid); end
        total++;
        if (bus.o_hop !== 7'd0 || bus.o_count !== 16'd0 || bus.o_isum !== 32'sd0 ||
            bus.o_qsum !== 32'sd0 || bus.o_sat !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_data: got hop=%0d count=%0d isum=%0d qsum=%0d sat=%0b, required all 0",
                     bus.o_hop, bus.o_count, bus.o_isum, bus.o_qsum, bus.o_sat);
        end
        for (int c = 0; c < 10; c++) cycle(1, 123, -45, 0, 0, 1);
        tick(2);
        total++;
        if (state !== 1'b0 || bus.o_tvalid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL idle_samples: got state=%0b tvalid=%0b, required state=0 tvalid=0", state, bus.o_tvalid);
        end
    endtask

    task automatic test_long_hop();
        cycle(0, 0, 0, 1, 0, 3);
        total++;
        if (state !== 1'b1) begin bad++; $display("[TB] FAIL long_state: got %0b, required 1", state); end
        for (int c = 0; c < 100; c++) cycle(1, 16000, -16000, 0, 0, 3);
        expect_rec(3, 100, 1600000, -1600000, 0);
        drive(0, 0, 0, 1, 0, 4);
        total++;
        if (bus.o_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL long_tvalid_early: got %0b, required 0", bus.o_tvalid); end
        tick(1);
        total++;
        if (bus.o_tvalid !== 1'b1) begin bad++; $display("[TB] FAIL long_tvalid_latency: got %0b, required 1", bus.o_tvalid); end
        for (int c = 0; c < 3; c++) cycle(0, 0, 0, 0, 0, 4);
        total++;
        if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL long_drain: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_sparse();
        expect_rec(4, 0, 0, 0, 0);
        for (int c = 0; c < 20; c++) begin
            if (c == 10) expect_rec(5, 5, -25, 35, 0);
            cycle((c % 2) == 0, -5, 7, (c == 0) || (c == 10), 0, 5 + c / 10);
        end
        expect_rec(6, 5, -25, 35, 0);
        cycle(0, 0, 0, 1, 0, 7);
        for (int c = 0; c < 3; c++) cycle(0, 0, 0, 0, 0, 7);
        total++;
        if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL sparse_drain: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_saturation();
        expect_rec(7, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 8);
        for (int c = 0; c < 20; c++) cycle(1, 1, 2, 0, 0, 8);
        expect_rec(8, 20, 20, 40, 0);
        cycle(0, 0, 0, 1, 0, 9);
        total++;
        if (bus2.o_tvalid !== 1'b1 || bus2.o_hop !== 7'd8) begin
            bad++;
            $display("[TB] FAIL sat_record: got tvalid=%0b hop=%0d, required tvalid=1 hop=8", bus2.o_tvalid, bus2.o_hop);
        end
        total++;
        if (bus2.o_count !== 4'd15) begin bad++; $display("[TB] FAIL sat_count: got %0d, required 15", bus2.o_count); end
        total++;
        if (bus2.o_isum !== 20'sd15 || bus2.o_qsum !== 20'sd30) begin
            bad++;
            $display("[TB] FAIL sat_sums: got isum=%0d qsum=%0d, required isum=15 qsum=30", bus2.o_isum, bus2.o_qsum);
        end
        total++;
        if (bus2.o_sat !== 1'b1) begin bad++; $display("[TB] FAIL sat_flag: got %0b, required 1", bus2.o_sat); end
        for (int c = 0; c < 3; c++) cycle(0, 0, 0, 0, 0, 9);
    endtask

    task automatic test_overflow();
        bus.o_tready = 1'b0;
        expect_rec(9, 0, 0, 0, 0);
        for (int h = 10; h <= 13; h++) begin
            cycle(0, 0, 0, 1, 0, h);
            for (int c = 0; c < 3; c++) cycle(1, h, -h, 0, 0, h);
            expect_rec(h, 3, 3 * h, -3 * h, 0);
        end
        for (int c = 0; c < 4; c++) begin
            total++;
            if (bus.o_tvalid !== 1'b1 || bus.o_hop !== 7'd9 || bus.o_count !== 16'd0) begin
                bad++;
                $display("[TB] FAIL stall_hold: got tvalid=%0b hop=%0d count=%0d, required tvalid=1 hop=9 count=0",
                         bus.o_tvalid, bus.o_hop, bus.o_count);
            end
            cycle(0, 0, 0, 0, 0, 13);
        end
        total++;
        if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL overflow_early: got %0b, required 0", overflow); end
        bus.o_tready = 1'b1;
        cycle(0, 0, 0, 1, 0, 14);
        bus.o_tready = 1'b0;
        total++;
        if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL push_with_pop: got overflow=%0b, required 0", overflow); end
        for (int c = 0; c < 3; c++) cycle(1, 14, -14, 0, 0, 14);
        cycle(0, 0, 0, 1, 0, 15);
        total++;
        if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL overflow_set: got %0b, required 1", overflow); end
        cycle(0, 0, 0, 0, 0, 15);
        total++;
        if (bus.o_hop !== 7'd10 || bus.o_count !== 16'd3 || bus.o_isum !== 32'sd30) begin
            bad++;
            $display("[TB] FAIL stall_head: got hop=%0d count=%0d isum=%0d, required hop=10 count=3 isum=30",
                     bus.o_hop, bus.o_count, bus.o_isum);
        end
        bus.o_tready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) cycle(0, 0, 0, 0, 0, 15);
        total++;
        if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL overflow_drain: got %0d pending, required 0", exp_q.size()); end
        total++;
        if (bus.o_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL tvalid_after_last_pop: got %0b, required 0", bus.o_tvalid); end
    endtask

    task automatic test_hop_rst();
        expect_rec(15, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 20);
        for (int c = 0; c < 50; c++) cycle(1, 100, -100, 0, 0, 20);
        cycle(1, 100, -100, 0, 1, 20);
        total++;
        if (state !== 1'b0) begin bad++; $display("[TB] FAIL hop_rst_state: got %0b, required 0", state); end
        for (int c = 0; c < 5; c++) cycle(1, 7, 7, 0, 0, 20);
        cycle(0, 0, 0, 1, 0, 21);
        total++;
        if (state !== 1'b1 || bus.o_tvalid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL aborted_hop: got state=%0b tvalid=%0b, required state=1 tvalid=0", state, bus.o_tvalid);
        end
        for (int c = 0; c < 10; c++) cycle(1, 2, 3, 0, 0, 21);
        expect_rec(21, 10, 20, 30, 0);
        cycle(0, 0, 0, 1, 0, 22);
        for (int c = 0; c < 2; c++) cycle(0, 0, 0, 0, 0, 22);
        cycle(0, 0, 0, 1, 1, 23);
        total++;
        if (state !== 1'b0 || bus.o_tvalid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rst_with_edge: got state=%0b tvalid=%0b, required state=0 tvalid=0", state, bus.o_tvalid);
        end
        for (int c = 0; c < 3; c++) cycle(0, 0, 0, 0, 0, 23);
        total++;
        if (exp_q.size() != 0 || overflow !== 1'b1) begin
            bad++;
            $display("[TB] FAIL hop_rst_end: got pending=%0d overflow=%0b, required pending=0 overflow=1", exp_q.size(), overflow);
        end
    endtask

    initial begin
        test_reset();
        test_long_hop();
        test_sparse();
        test_saturation();
        test_overflow();
        test_hop_rst();
        tick(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
